// File: rtl/vip_seq_pkg.sv
// vip_seq_pkg: shared state encoding, frame config type and defaults for the VIP frame sequencer.
package vip_seq_pkg;
  localparam int DIM_W = 16;
  localparam int DEF_GAP_CYCLES = 2;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND_CTRL = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] FRAME_DONE = 2'd3;
  typedef struct packed {
    logic [DIM_W-1:0] width;
    logic [DIM_W-1:0] height;
    logic [3:0] interlaced;
  } vip_cfg_t;
  function automatic logic cfg_ok(input vip_cfg_t c);
    return (c.width != '0) && (c.height != '0);
  endfunction
endpackage

// File: rtl/vip_frame_position_counter.sv
// vip_frame_position_counter: column/row position within a frame, advancing on accepted beats.
module vip_frame_position_counter
  import vip_seq_pkg::*;
#(
  parameter int PIXELS_PER_BEAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             acc_i,
  input  logic [DIM_W-1:0] width_i,
  input  logic [DIM_W-1:0] height_i,
  output logic             last_o
);
  localparam logic [DIM_W:0] STEP = (DIM_W+1)'(PIXELS_PER_BEAT);
  logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
  logic [DIM_W:0] col_next;
  logic eol;
  assign col_next = {1'b0, col_q} + STEP;
  assign eol = col_next >= {1'b0, width_i};
  assign last_o = eol && (row_q == height_i - 1'b1);
  always_comb begin
    col_d = clear_i ? '0 : acc_i ? (eol ? '0 : col_next[DIM_W-1:0]) : col_q;
    row_d = clear_i ? '0 : (acc_i && eol) ? row_q + 1'b1 : row_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
endmodule

// File: rtl/vip_frame_sequencer.sv
// vip_frame_sequencer: frame-level controller for the VIP control packet encoder;
// shadows runtime config, pulses vip_ctrl_send per frame and gates pixels with end_of_video.
module vip_frame_sequencer
  import vip_seq_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int PIXELS_PER_BEAT  = 1,
  parameter int GAP_CYCLES       = DEF_GAP_CYCLES,
  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic [3:0]       cfg_interlaced,
  input  logic             cfg_valid,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [DW-1:0]    pix_data,
  output logic             enc_din_valid,
  input  logic             enc_din_ready,
  output logic [DW-1:0]    enc_din_data,
  output logic             enc_end_of_video,
  output logic [DIM_W-1:0] enc_width,
  output logic [DIM_W-1:0] enc_height,
  output logic [3:0]       enc_interlaced,
  output logic             enc_vip_ctrl_send,
  input  logic             enc_vip_ctrl_busy,
  output logic [DIM_W-1:0] frame_count,
  output logic             err_zero_size
);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  logic [1:0] state_q, state_d;
  vip_cfg_t pend_q, pend_d, act_q, act_d;
  logic [7:0] gap_q, gap_d;
  logic [DIM_W-1:0] fcnt_q, fcnt_d;
  logic err_q, err_d;
  logic streaming, acc, last, gap_done, apply, go, frame_end;
  assign streaming = state_q == STREAM;
  assign pix_ready = enc_din_ready && streaming;
  assign enc_din_valid = pix_valid && streaming;
  assign enc_din_data = pix_data;
  assign acc = pix_valid && pix_ready;
  assign enc_end_of_video = streaming && last;
  assign frame_end = acc && last;
  assign gap_done = gap_q == GAP_LAST;
  // send is low in FRAME_DONE, so sampling busy here cannot deadlock against our own pulse
  assign apply = (state_q == IDLE) || (state_q == FRAME_DONE && gap_done && !enc_vip_ctrl_busy);
  assign go = enable && cfg_ok(pend_q);
  assign enc_vip_ctrl_send = state_q == SEND_CTRL;
  assign enc_width = act_q.width;
  assign enc_height = act_q.height;
  assign enc_interlaced = act_q.interlaced;
  assign frame_count = fcnt_q;
  assign err_zero_size = err_q;
  always_comb begin
    state_d = state_q == IDLE      ? (go ? SEND_CTRL : IDLE) :
              state_q == SEND_CTRL ? STREAM :
              state_q == STREAM    ? (frame_end ? FRAME_DONE : STREAM) :
              apply                ? (go ? SEND_CTRL : IDLE) : FRAME_DONE;
    pend_d = cfg_valid ? '{width: cfg_width, height: cfg_height, interlaced: cfg_interlaced} : pend_q;
    act_d = apply ? pend_q : act_q;
    // error reflects the config we are refusing to start while enabled
    err_d = apply ? (enable && !cfg_ok(pend_q)) : err_q;
    gap_d = (state_q == FRAME_DONE && !gap_done) ? gap_q + 8'd1 : (state_q == FRAME_DONE ? gap_q : 8'd0);
    fcnt_d = (streaming && frame_end) ? fcnt_q + 1'b1 : fcnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q <= '0;
      act_q <= '0;
      gap_q <= '0;
      fcnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      act_q <= act_d;
      gap_q <= gap_d;
      fcnt_q <= fcnt_d;
      err_q <= err_d;
    end
  end
  vip_frame_position_counter #(.PIXELS_PER_BEAT(PIXELS_PER_BEAT)) u_pos (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_q == SEND_CTRL),
    .acc_i   (acc),
    .width_i (act_q.width),
    .height_i(act_q.height),
    .last_o  (last)
  );
endmodule

// File: tb/tb_vip_frame_sequencer.sv
// tb_vip_frame_sequencer: directed checks of frame sequencing, backpressure, config timing and reset.
module tb_vip_frame_sequencer;
  logic clk = 0, rst = 1, enable = 0, cfg_valid = 0, pix_valid = 0, enc_din_ready = 0, enc_vip_ctrl_busy = 0;
  logic [15:0] cfg_width = 0, cfg_height = 0;
  logic [3:0] cfg_interlaced = 0;
  logic [23:0] pix_data = 0, enc_din_data;
  logic pix_ready, enc_din_valid, enc_end_of_video, enc_vip_ctrl_send, err_zero_size;
  logic [15:0] enc_width, enc_height, frame_count;
  logic [3:0] enc_interlaced;
  int n_run = 0, n_fail = 0;
  int w, b, n;

  vip_frame_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_interlaced(cfg_interlaced), .cfg_valid(cfg_valid), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .enc_din_valid(enc_din_valid), .enc_din_ready(enc_din_ready),
    .enc_din_data(enc_din_data), .enc_end_of_video(enc_end_of_video), .enc_width(enc_width),
    .enc_height(enc_height), .enc_interlaced(enc_interlaced), .enc_vip_ctrl_send(enc_vip_ctrl_send),
    .enc_vip_ctrl_busy(enc_vip_ctrl_busy), .frame_count(frame_count), .err_zero_size(err_zero_size)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input int cw, input int ch, input int ci);
    cfg_width = 16'(cw);
    cfg_height = 16'(ch);
    cfg_interlaced = 4'(ci);
    cfg_valid = 1;
    @(posedge clk); #1;
    cfg_valid = 0;
  endtask

  task automatic wait_send(input int max, output int wt);
    wt = -1;
    for (int i = 0; i < max; i++) begin
      #1;
      if (enc_vip_ctrl_send) begin
        wt = i;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic stream(input string tag, input int exp_beats, input int exp_w, input bit toggle,
                        input int drop_at, input int cfg_at, input int cw, input int ch, input int ci);
    int beats = 0, bad = 0, held = 0, unstable = 0, k = 0;
    bit done = 0, cfg_sent = 0;
    @(posedge clk); #1;
    while (!done && k < 200) begin
      enc_din_ready = toggle ? (k % 2 == 0) : 1'b1;
      if (beats == drop_at) enable = 0;
      cfg_valid = 0;
      if (beats == cfg_at && !cfg_sent) begin
        cfg_width = 16'(cw);
        cfg_height = 16'(ch);
        cfg_interlaced = 4'(ci);
        cfg_valid = 1;
        cfg_sent = 1;
      end
      #1;
      if (enc_vip_ctrl_send) bad++;
      if (enc_width != 16'(exp_w)) unstable++;
      if (enc_end_of_video && !enc_din_ready) held++;
      if (pix_valid && pix_ready) begin
        beats++;
        if (enc_end_of_video != (beats == exp_beats)) bad++;
        if (enc_end_of_video) done = 1;
      end
      @(posedge clk); #1;
      k++;
    end
    cfg_valid = 0;
    enc_din_ready = 1;
    chk({tag, "_beats"}, beats, exp_beats);
    chk({tag, "_eov_place"}, bad, 0);
    chk({tag, "_width_stable"}, unstable, 0);
    chk({tag, "_eov_held"}, held, toggle ? 1 : 0);
  endtask

  initial begin
    pix_data = 24'hA5C3F0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_send", enc_vip_ctrl_send, 0);
    chk("rst_din_valid", enc_din_valid, 0);
    chk("rst_eov", enc_end_of_video, 0);
    chk("rst_fcnt", frame_count, 0);
    chk("rst_err", err_zero_size, 0);
    chk("rst_width", enc_width, 0);
    chk("data_pass", enc_din_data, 24'hA5C3F0);
    rst = 0;
    pix_valid = 1;
    enc_din_ready = 1;
    @(posedge clk); #1;
    cfg(4, 2, 0);
    chk("idle_ready", pix_ready, 0);
    enable = 1;
    wait_send(10, w);
    chk("f1_latency", w, 1);
    chk("f1_width", enc_width, 4);
    chk("f1_height", enc_height, 2);
    stream("f1", 8, 4, 0, -1, -1, 0, 0, 0);
    chk("f1_fcnt", frame_count, 1);
    wait_send(10, w);
    chk("f2_gap", w, 2);
    stream("f2", 8, 4, 1, -1, 2, 8, 1, 3);
    chk("f2_fcnt", frame_count, 2);
    wait_send(10, w);
    chk("f3_gap", w, 2);
    chk("f3_width", enc_width, 8);
    chk("f3_height", enc_height, 1);
    chk("f3_il", enc_interlaced, 3);
    stream("f3", 8, 8, 0, -1, 1, 4, 2, 0);
    wait_send(10, w);
    chk("f4_width", enc_width, 4);
    stream("f4", 8, 4, 0, 3, -1, 0, 0, 0);
    chk("f4_fcnt", frame_count, 4);
    wait_send(20, w);
    chk("drop_no_send", w, -1);
    chk("drop_idle", enc_din_valid, 0);
    cfg(0, 2, 0);
    enable = 1;
    wait_send(5, w);
    chk("zero_no_send", w, -1);
    chk("zero_err", err_zero_size, 1);
    cfg(2, 2, 0);
    wait_send(5, w);
    chk("zero_fix_latency", w, 1);
    chk("zero_err_clear", err_zero_size, 0);
    stream("f5", 4, 2, 0, -1, 1, 4, 2, 0);
    chk("f5_fcnt", frame_count, 5);
    wait_send(10, w);
    chk("f6_width", enc_width, 4);
    b = 0;
    n = 0;
    @(posedge clk); #1;
    while (b < 5 && n < 50) begin
      #1;
      if (pix_valid && pix_ready) b++;
      @(posedge clk); #1;
      n++;
    end
    chk("f6_beats_before_rst", b, 5);
    rst = 1;
    enable = 0;
    @(posedge clk); #1;
    chk("mid_rst_din_valid", enc_din_valid, 0);
    chk("mid_rst_ready", pix_ready, 0);
    chk("mid_rst_eov", enc_end_of_video, 0);
    chk("mid_rst_send", enc_vip_ctrl_send, 0);
    chk("mid_rst_fcnt", frame_count, 0);
    chk("mid_rst_width", enc_width, 0);
    rst = 0;
    @(posedge clk); #1;
    cfg(2, 1, 5);
    enable = 1;
    wait_send(10, w);
    chk("post_rst_latency", w, 1);
    chk("post_rst_width", enc_width, 2);
    chk("post_rst_height", enc_height, 1);
    chk("post_rst_il", enc_interlaced, 5);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
